// File: rtl/utils_pkg.sv
// Shared load/store types: LSU width codes, load descriptor, writeback bundle.
// Imported by the writeback load queue and its descriptor FIFO.
package utils_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_D  = 3'b011,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101,
        LSU_WU = 3'b110
    } lsu_width_e;

    typedef struct packed {
        logic [4:0] rd;
        lsu_width_e width;
        logic [2:0] lsb;
    } ld_desc_t;

    typedef struct packed {
        logic                we;
        logic [4:0]          rd_addr;
        logic [MAX_XLEN-1:0] data;
    } s_wb_t;

endpackage

// File: rtl/wb_load_queue_if.sv
// Load issue / load return handshake bundle between LSU bus side and queue.
// master drives requests and returns, slave is the load queue.
interface wb_load_queue_if #(
    parameter int XLEN = 32
);
    localparam int LSBW = $clog2(XLEN / 8);

    logic            ld_req_valid_i;
    logic            ld_req_ready_o;
    logic [4:0]      ld_rd_addr_i;
    logic [2:0]      ld_width_i;
    logic [LSBW-1:0] ld_addr_lsb_i;
    logic            ld_rvalid_i;
    logic            ld_rready_o;
    logic [XLEN-1:0] ld_rdata_i;
    logic            ld_rerr_i;

    modport master (
        output ld_req_valid_i, ld_rd_addr_i,
        output ld_width_i, ld_addr_lsb_i,
        output ld_rvalid_i, ld_rdata_i, ld_rerr_i,
        input  ld_req_ready_o, ld_rready_o
    );

    modport slave (
        input  ld_req_valid_i, ld_rd_addr_i,
        input  ld_width_i, ld_addr_lsb_i,
        input  ld_rvalid_i, ld_rdata_i, ld_rerr_i,
        output ld_req_ready_o, ld_rready_o
    );

endinterface

// File: rtl/lsu_desc_fifo.sv
// In-order descriptor FIFO for outstanding loads.
// Exposes per-entry valid and rd so the owner can build a pending mask.
module lsu_desc_fifo
    import utils_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ld_desc_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    output T              head_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [DEPTH-1:0] vld_o,
    output logic [4:0]    rd_o [DEPTH]
);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [DEPTH-1:0] vld;
    logic           push;
    logic           pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];
    assign count_o = count;
    assign vld_o   = vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign rd_o[i] = mem[i].rd;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_load_queue.sv
// Writeback load queue: tracks outstanding loads, formats returned data and
// arbitrates the single register-file write port between loads and the ALU.
module wb_load_queue
    import utils_pkg::*;
#(
    parameter int  XLEN     = 32,
    parameter int  OT_DEPTH = 4,
    localparam int CW       = $clog2(OT_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    input  logic            ex_we_rd_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic [XLEN-1:0] ex_result_i,
    wb_load_queue_if.slave  ld_bus,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_rd_data_o,
    output logic            ex_stall_o,
    output logic [31:0]     pend_rd_mask_o,
    output logic [CW-1:0]   ld_pending_o,
    output logic            ld_err_o,
    output logic [4:0]      ld_err_rd_o
);

    ld_desc_t              din;
    ld_desc_t              head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [OT_DEPTH-1:0]   vld;
    logic [4:0]            rd_v [OT_DEPTH];
    logic [XLEN-1:0]       ld_data;
    s_wb_t                 wb;

    function automatic logic [XLEN-1:0] fmt_load(
        input logic [XLEN-1:0] d,
        input lsu_width_e      w,
        input logic [2:0]      lsb
    );
        logic [XLEN-1:0] s;
        logic [63:0]     t;
        s = d >> {lsb, 3'b000};
        t = 64'(s);
        case (w)
            LSU_B:  t = {{56{s[7]}}, s[7:0]};
            LSU_H:  t = {{48{s[15]}}, s[15:0]};
            LSU_BU: t = {56'd0, s[7:0]};
            LSU_HU: t = {48'd0, s[15:0]};
            LSU_W:  if (XLEN == 64) t = {{32{s[31]}}, s[31:0]};
            LSU_WU: if (XLEN == 64) t = {32'd0, s[31:0]};
            default: t = 64'(s);
        endcase
        return t[XLEN-1:0];
    endfunction

    always_comb begin
        din       = '0;
        din.rd    = ld_bus.ld_rd_addr_i;
        din.width = lsu_width_e'(ld_bus.ld_width_i);
        din.lsb   = 3'(ld_bus.ld_addr_lsb_i);
    end

    assign push = ld_bus.ld_req_valid_i && !full;
    assign pop  = ld_bus.ld_rvalid_i && !empty;

    assign ld_bus.ld_req_ready_o = !full;
    assign ld_bus.ld_rready_o    = !empty;

    lsu_desc_fifo #(
        .DEPTH (OT_DEPTH),
        .T     (ld_desc_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (ld_pending_o),
        .full_o  (full),
        .empty_o (empty),
        .vld_o   (vld),
        .rd_o    (rd_v)
    );

    assign ld_data = fmt_load(ld_bus.ld_rdata_i, head.width, head.lsb);

    // A good load return owns the port; the ALU is held off for a cycle.
    always_comb begin
        wb         = '0;
        ex_stall_o = 1'b0;
        if (pop && !ld_bus.ld_rerr_i) begin
            wb.we      = (head.rd != 5'd0);
            wb.rd_addr = head.rd;
            wb.data    = MAX_XLEN'(ld_data);
            ex_stall_o = ex_valid_i && ex_we_rd_i;
        end else begin
            wb.we      = ex_valid_i && ex_we_rd_i
                         && (ex_rd_addr_i != 5'd0);
            wb.rd_addr = ex_rd_addr_i;
            wb.data    = MAX_XLEN'(ex_result_i);
        end
    end

    assign wb_we_o      = wb.we;
    assign wb_rd_addr_o = wb.rd_addr;
    assign wb_rd_data_o = wb.data[XLEN-1:0];

    always_comb begin
        pend_rd_mask_o = '0;
        for (int i = 0; i < OT_DEPTH; i++) begin
            if (vld[i]) pend_rd_mask_o[rd_v[i]] = 1'b1;
        end
        pend_rd_mask_o[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_err_o    <= 1'b0;
            ld_err_rd_o <= 5'd0;
        end else begin
            ld_err_o <= pop && ld_bus.ld_rerr_i;
            if (pop && ld_bus.ld_rerr_i) begin
                ld_err_rd_o <= head.rd;
            end
        end
    end

endmodule

// File: tb/tb_wb_load_queue.sv
// Bench for wb_load_queue: directed scenarios plus random traffic on XLEN=32,
// directed checks on XLEN=64, all against a queue-based reference model.
module tb_wb_load_queue;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_load_queue_if #(.XLEN(32)) bus_a ();
    wb_load_queue_if #(.XLEN(64)) bus_b ();

    logic        exv_a, exwe_a;
    logic [4:0]  exrd_a;
    logic [31:0] exres_a;
    logic        we_a, stall_a, err_a;
    logic [4:0]  rd_a, err_rd_a;
    logic [31:0] data_a, mask_a;
    logic [2:0]  pend_a;

    logic        exv_b, exwe_b;
    logic [4:0]  exrd_b;
    logic [63:0] exres_b;
    logic        we_b, stall_b, err_b;
    logic [4:0]  rd_b, err_rd_b;
    logic [63:0] data_b;
    logic [31:0] mask_b;
    logic [2:0]  pend_b;

    wb_load_queue #(.XLEN(32), .OT_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .ex_valid_i(exv_a), .ex_we_rd_i(exwe_a),
        .ex_rd_addr_i(exrd_a), .ex_result_i(exres_a),
        .ld_bus(bus_a),
        .wb_we_o(we_a), .wb_rd_addr_o(rd_a), .wb_rd_data_o(data_a),
        .ex_stall_o(stall_a), .pend_rd_mask_o(mask_a),
        .ld_pending_o(pend_a), .ld_err_o(err_a), .ld_err_rd_o(err_rd_a)
    );

    wb_load_queue #(.XLEN(64), .OT_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .ex_valid_i(exv_b), .ex_we_rd_i(exwe_b),
        .ex_rd_addr_i(exrd_b), .ex_result_i(exres_b),
        .ld_bus(bus_b),
        .wb_we_o(we_b), .wb_rd_addr_o(rd_b), .wb_rd_data_o(data_b),
        .ex_stall_o(stall_b), .pend_rd_mask_o(mask_b),
        .ld_pending_o(pend_b), .ld_err_o(err_b), .ld_err_rd_o(err_rd_b)
    );

    typedef struct {
        int rd;
        int w;
        int lsb;
    } mdesc_t;

    mdesc_t q[$];
    bit     m_err;
    int     m_err_rd;
    int     compared = 0;
    int     mismatched = 0;

    logic        obs_we, obs_ready, obs_stall, obs_err;
    logic [4:0]  obs_rd, obs_err_rd;
    logic [63:0] obs_data;
    logic [31:0] obs_mask;
    logic [2:0]  obs_pend;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Width codes: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU, 7 undefined.
    function automatic logic [63:0] ref_fmt(input int xlen, input int w,
                                            input int lsb,
                                            input logic [63:0] d);
        logic [63:0] v;
        int bits;
        bit sgn;
        v = d >> (8 * lsb);
        bits = 0;
        sgn = 0;
        case (w)
            0: begin bits = 8;  sgn = 1; end
            1: begin bits = 16; sgn = 1; end
            2: if (xlen == 64) begin bits = 32; sgn = 1; end
            4: bits = 8;
            5: bits = 16;
            6: if (xlen == 64) bits = 32;
            default: bits = 0;
        endcase
        if (bits != 0) begin
            v = v % (64'd1 << bits);
            if (sgn && v >= (64'd1 << (bits - 1)))
                v = v - (64'd1 << bits);
        end
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic step_a(input string tag,
                          input bit rv, input int rd, input int w,
                          input int lsb, input bit rvl,
                          input logic [31:0] rdata, input bit rerr,
                          input bit exv, input bit exwe, input int exrd,
                          input logic [31:0] exres);
        bit          e_pop, e_push, e_we, e_stall;
        int          e_rd;
        logic [63:0] e_data;
        logic [31:0] e_mask;
        bus_a.ld_req_valid_i = rv;
        bus_a.ld_rd_addr_i   = 5'(rd);
        bus_a.ld_width_i     = 3'(w);
        bus_a.ld_addr_lsb_i  = 2'(lsb);
        bus_a.ld_rvalid_i    = rvl;
        bus_a.ld_rdata_i     = rdata;
        bus_a.ld_rerr_i      = rerr;
        exv_a   = exv;
        exwe_a  = exwe;
        exrd_a  = 5'(exrd);
        exres_a = exres;
        #1;
        e_pop  = rvl && (q.size() > 0);
        e_push = rv && (q.size() < 4);
        e_mask = '0;
        foreach (q[i]) if (q[i].rd != 0) e_mask[q[i].rd] = 1'b1;
        if (e_pop && !rerr) begin
            e_we    = (q[0].rd != 0);
            e_rd    = q[0].rd;
            e_data  = ref_fmt(32, q[0].w, q[0].lsb, {32'd0, rdata});
            e_stall = exv && exwe;
        end else begin
            e_we    = exv && exwe && (exrd != 0);
            e_rd    = exrd;
            e_data  = {32'd0, exres};
            e_stall = 1'b0;
        end
        obs_we     = we_a;
        obs_rd     = rd_a;
        obs_data   = {32'd0, data_a};
        obs_stall  = stall_a;
        obs_ready  = bus_a.ld_req_ready_o;
        obs_mask   = mask_a;
        obs_pend   = pend_a;
        obs_err    = err_a;
        obs_err_rd = err_rd_a;
        chk({tag, "/ready"}, obs_ready, q.size() < 4);
        chk({tag, "/rready"}, bus_a.ld_rready_o, q.size() > 0);
        chk({tag, "/pend"}, obs_pend, q.size());
        chk({tag, "/mask"}, obs_mask, e_mask);
        chk({tag, "/we"}, obs_we, e_we);
        if (e_we) begin
            chk({tag, "/rd"}, obs_rd, e_rd);
            chk({tag, "/data"}, obs_data, e_data);
        end
        chk({tag, "/stall"}, obs_stall, e_stall);
        chk({tag, "/err"}, obs_err, m_err);
        if (m_err) chk({tag, "/err_rd"}, obs_err_rd, m_err_rd);
        @(posedge clk);
        if (e_pop) begin
            m_err = rerr;
            if (rerr) m_err_rd = q[0].rd;
            q.delete(0);
        end else begin
            m_err = 1'b0;
        end
        if (e_push) q.push_back('{rd, w, lsb});
        #1;
    endtask

    task automatic idle_b();
        bus_b.ld_req_valid_i = 1'b0;
        bus_b.ld_rd_addr_i   = '0;
        bus_b.ld_width_i     = '0;
        bus_b.ld_addr_lsb_i  = '0;
        bus_b.ld_rvalid_i    = 1'b0;
        bus_b.ld_rdata_i     = '0;
        bus_b.ld_rerr_i      = 1'b0;
        exv_b = 1'b0; exwe_b = 1'b0; exrd_b = '0; exres_b = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_err = 1'b0;
        m_err_rd = 0;
    endtask

    initial begin
        idle_b();
        bus_a.ld_req_valid_i = 1'b0;
        bus_a.ld_rvalid_i    = 1'b0;
        bus_a.ld_rerr_i      = 1'b0;
        bus_a.ld_rd_addr_i   = '0;
        bus_a.ld_width_i     = '0;
        bus_a.ld_addr_lsb_i  = '0;
        bus_a.ld_rdata_i     = '0;
        exv_a = 1'b0; exwe_a = 1'b0; exrd_a = '0; exres_a = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state with an ALU write flowing straight through.
        step_a("rst", 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h1234_5678);
        chk("rst/ready_c", obs_ready, 1'b1);
        chk("rst/mask_c", obs_mask, 32'd0);
        chk("rst/alu_we_c", obs_we, 1'b1);

        // LB rd5 lsb3 returning 0x80FFFFFF.
        step_a("lb_iss", 1, 5, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step_a("lb_ret", 0, 0, 0, 0, 1, 32'h80FF_FFFF, 0,
               0, 0, 0, 0);
        chk("lb/data_c", obs_data, 64'hFFFF_FF80);
        chk("lb/rd_c", obs_rd, 5'd5);

        // Fill to depth, then a 5th issue racing a return.
        for (int i = 1; i <= 4; i++)
            step_a("fill", 1, i, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a("full", 1, 20, 1, 1, 1, 32'hA5A5_5A5A, 0,
               0, 0, 0, 0);
        chk("full/ready_c", obs_ready, 1'b0);
        chk("full/pend_c", obs_pend, 3'd4);
        step_a("fifth", 1, 20, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("fifth/pend_c", obs_pend, 3'd3);
        chk("fifth/ready_c", obs_ready, 1'b1);
        step_a("after5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("after5/pend_c", obs_pend, 3'd4);
        for (int i = 0; i < 4; i++)
            step_a("drain", 0, 0, 0, 0, 1, $urandom, 0,
                   0, 0, 0, 0);

        // LHU rd7 lsb2 against a competing ALU write to rd9.
        step_a("lhu_iss", 1, 7, 5, 2, 0, 0, 0, 0, 0, 0, 0);
        step_a("lhu_ret", 0, 0, 0, 0, 1, 32'hBEEF_0000, 0,
               1, 1, 9, 32'hCAFE_0009);
        chk("lhu/data_c", obs_data, 64'h0000_BEEF);
        chk("lhu/stall_c", obs_stall, 1'b1);
        step_a("alu_retry", 0, 0, 0, 0, 0, 0, 0,
               1, 1, 9, 32'hCAFE_0009);
        chk("retry/rd_c", obs_rd, 5'd9);

        // Two loads to rd3: bit survives the first pop.
        step_a("dup1", 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a("dup2", 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_a("dup_pop1", 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0, 0);
        step_a("dup_pop2", 0, 0, 0, 0, 1, 32'h22, 0, 0, 0, 0, 0);
        chk("dup/mask_mid_c", obs_mask[3], 1'b1);
        step_a("dup_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dup/mask_end_c", obs_mask[3], 1'b0);

        // Bus error on rd12.
        step_a("err_iss", 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a("err_ret", 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1,
               0, 0, 0, 0);
        chk("err/we_c", obs_we, 1'b0);
        step_a("err_pulse", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err/flag_c", obs_err, 1'b1);
        chk("err/rd_c", obs_err_rd, 5'd12);
        chk("err/pend_c", obs_pend, 3'd0);
        step_a("err_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic, including returns while empty.
        for (int n = 0; n < 400; n++) begin
            step_a("rand",
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 2) != 0, $urandom,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 15), $urandom);
        end

        // XLEN=64: LW lsb4 sign-extends the upper word.
        do_reset();
        idle_b();
        bus_b.ld_req_valid_i = 1'b1;
        bus_b.ld_rd_addr_i   = 5'd6;
        bus_b.ld_width_i     = 3'd2;
        bus_b.ld_addr_lsb_i  = 3'd4;
        @(posedge clk);
        #1;
        idle_b();
        bus_b.ld_rvalid_i = 1'b1;
        bus_b.ld_rdata_i  = 64'h8000_0001_1234_5678;
        #1;
        chk("x64/we", we_b, 1'b1);
        chk("x64/rd", rd_b, 5'd6);
        chk("x64/data", data_b, 64'hFFFF_FFFF_8000_0001);
        @(posedge clk);
        #1;
        idle_b();
        for (int i = 8; i <= 10; i++) begin
            bus_b.ld_req_valid_i = 1'b1;
            bus_b.ld_rd_addr_i   = 5'(i);
            @(posedge clk);
            #1;
        end
        idle_b();
        chk("x64/pend3", pend_b, 3'd3);
        chk("x64/mask3", mask_b, 32'h0000_0700);
        do_reset();
        chk("x64/rst_mask", mask_b, 32'd0);
        chk("x64/rst_pend", pend_b, 3'd0);
        chk("x64/rst_rready", bus_b.ld_rready_o, 1'b0);
        bus_b.ld_rvalid_i = 1'b1;
        bus_b.ld_rdata_i  = 64'h0123_4567_89AB_CDEF;
        bus_b.ld_rerr_i   = 1'b1;
        #1;
        chk("x64/stale_we", we_b, 1'b0);
        @(posedge clk);
        #1;
        idle_b();
        chk("x64/stale_err", err_b, 1'b0);
        chk("x64/stale_pend", pend_b, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_load_queue.md
WB_LOAD_QUEUE -- requirements
Module: wb_load_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter OT_DEPTH, default 4, maximum outstanding loads; power of 2, at least 2.
REQ-003 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock; reset is synchronous and active-high.
REQ-004 SHALL have ALU writeback ports: ex_valid_i (in, 1), ex_we_rd_i (in, 1), ex_rd_addr_i (in, 5), ex_result_i (in, XLEN).
REQ-005 SHALL have load-issue ports: ld_req_valid_i (in, 1), ld_req_ready_o (out, 1), ld_rd_addr_i (in, 5), ld_width_i (in, 3, lsu width enum), ld_addr_lsb_i (in, log2(XLEN/8), byte offset).
REQ-006 SHALL have load-return ports: ld_rvalid_i (in, 1), ld_rready_o (out, 1), ld_rdata_i (in, XLEN), ld_rerr_i (in, 1, bus error).
REQ-007 SHALL have register-file write ports: wb_we_o (out, 1), wb_rd_addr_o (out, 5), wb_rd_data_o (out, XLEN).
REQ-008 SHALL have status ports: ex_stall_o (out, 1, ALU write refused), pend_rd_mask_o (out, 32, rd with queued load), ld_pending_o (out, log2(OT_DEPTH)+1, queue occupancy), ld_err_o (out, 1), ld_err_rd_o (out, 5).

Function
REQ-009 SHALL record one descriptor {rd, width, lsb} per accepted load; accept means ld_req_valid_i and ld_req_ready_o both high on a rising clk edge.
REQ-010 SHALL drive ld_req_ready_o = (occupancy < OT_DEPTH); at full, ready is low even if a pop occurs in the same cycle.
REQ-011 SHALL drive ld_rready_o = (occupancy > 0); returns arrive in issue order and pop the oldest descriptor on ld_rvalid_i and ld_rready_o.
REQ-012 SHALL ignore ld_rvalid_i while empty: no write, no pop, no error.
REQ-013 SHALL keep occupancy unchanged on a simultaneous push and pop; pointers wrap modulo OT_DEPTH.
REQ-014 SHALL format load data combinationally in the pop cycle, with zero latency from ld_rvalid_i to wb_*_o.
REQ-015 SHALL form formatted data as ld_rdata_i shifted right by 8*lsb, then sign-extended (B, H, W) or zero-extended (BU, HU, WU), or passed unchanged (D and any undefined code).
REQ-016 SHALL treat W, WU and D as undefined codes (data unchanged) when XLEN=32.
REQ-017 SHALL give a load return write-port priority: wb_we_o=1, wb_rd_addr_o=descriptor rd, wb_rd_data_o=formatted data.
REQ-018 SHALL, in a pop cycle where ex_valid_i and ex_we_rd_i are both high, assert ex_stall_o and drop the ALU write; EXEC holds and re-presents it next cycle.
REQ-019 SHALL, with no load write, drive wb_we_o = ex_valid_i and ex_we_rd_i, wb_rd_addr_o = ex_rd_addr_i, wb_rd_data_o = ex_result_i, and ex_stall_o = 0.
REQ-020 SHALL force wb_we_o=0 for rd=0 from either source; an x0 load still pops.
REQ-021 SHALL, for a pop with ld_rerr_i=1: write nothing, pop the descriptor, set ld_err_o=1 for exactly the next cycle with ld_err_rd_o=descriptor rd, and not stall the ALU.
REQ-022 SHALL drive pend_rd_mask_o bit r high iff any valid queued entry has rd=r, bit 0 always 0, derived from registered state only.
REQ-023 SHALL allow duplicate rd entries; the mask bit clears only when the last matching entry pops.

Reset
REQ-024 SHALL, while rst is high at a clk edge, clear pointers, occupancy, valid bits, ld_err_o and ld_err_rd_o.
REQ-025 SHALL, in the cycle after reset, show ld_req_ready_o=1, ld_rready_o=0, pend_rd_mask_o=0, ld_pending_o=0, and wb_we_o following the ALU inputs only.
REQ-026 SHALL discard any load in flight when reset is asserted mid-operation; later returns are ignored per REQ-012.

Structure
REQ-027 SHALL take from utils_pkg: the lsu width enum (existing B/H/BU/HU/W codes plus WU and D), the descriptor struct, and the s_wb_t output struct.
REQ-028 SHALL place the descriptor storage in one sub-module, lsu_desc_fifo, parameterised by depth and element type, exposing a per-entry valid/rd view for the mask.
REQ-029 SHALL keep formatting as a function inside wb_load_queue, with no sequential logic in the write-port mux.

Verification
REQ-030 SHALL cover: XLEN=32, issue LB rd=5 lsb=3, return 0x80FF_FFFF -> wb_we_o=1, rd 5, data 0xFFFF_FF80, same cycle.
REQ-031 SHALL cover: OT_DEPTH=4, 4 back-to-back issues, then a 5th with a same-cycle return -> 5th held (ready low), ld_pending_o 4 then 3, then 5th accepted next cycle.
REQ-032 SHALL cover: return LHU rd=7 lsb=2 data 0xBEEF_0000 while ALU writes rd 9 -> load write 0x0000_BEEF to rd 7, ex_stall_o=1, ALU write to rd 9 next cycle.
REQ-033 SHALL cover: two queued loads to rd 3 -> mask bit 3 stays high after first pop, clears after second.
REQ-034 SHALL cover: return with ld_rerr_i=1 for rd 12 -> no write, ld_err_o pulse one cycle later, ld_err_rd_o=12, occupancy decremented.
REQ-035 SHALL cover: XLEN=64, LW lsb=4 data 0x8000_0001_xxxx_xxxx -> 0xFFFF_FFFF_8000_0001; rst asserted with 3 pending -> mask 0, returns ignored.
